// File: rtl/prince_slayer_seq.sv
// Nibble-serial sequencer feeding a three-share masked PRINCE S-box and writing results back in place.
// Optional: define PRINCE_SEQ_IDLE_ZERO_EN to force o_sb_in* to zero while o_sb_valid is low.
module prince_slayer_seq #(
   parameter int unsigned SBOX_LAT = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [0:63] i_state0,
   input  logic [0:63] i_state1,
   input  logic [0:63] i_state2,
   output logic [0:3]  o_sb_in0,
   output logic [0:3]  o_sb_in1,
   output logic [0:3]  o_sb_in2,
   output logic        o_sb_valid,
   input  logic [0:3]  i_sb_out0,
   input  logic [0:3]  i_sb_out1,
   input  logic [0:3]  i_sb_out2,
   output logic [0:63] o_state0,
   output logic [0:63] o_state1,
   output logic [0:63] o_state2,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  issue_cnt;
   logic [4:0]  retire_cnt;
   logic [0:63] sh0_q, sh1_q, sh2_q;
   logic        issue_v, ret_v, last_retire, load;
   logic [3:0]  ret_idx;
   logic [5:0]  issue_base, ret_base;
   logic [0:3]  nib0, nib1, nib2;

   assign issue_v    = (state_q == RUN);
   assign load       = (state_q == IDLE) && i_start;
   assign issue_base = {issue_cnt, 2'b00};
   assign ret_base   = {ret_idx, 2'b00};
   assign nib0       = sh0_q[issue_base +: 4];
   assign nib1       = sh1_q[issue_base +: 4];
   assign nib2       = sh2_q[issue_base +: 4];

   // {valid, index} travels alongside each nibble so the returning shares land in the right slot
   generate
      if (SBOX_LAT == 0) begin : g_nodelay
         assign ret_v   = issue_v;
         assign ret_idx = issue_cnt;
      end else begin : g_delay
         logic       dl_v   [SBOX_LAT];
         logic [3:0] dl_idx [SBOX_LAT];
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int unsigned i = 0; i < SBOX_LAT; i++) begin
                  dl_v[i]   <= 1'b0;
                  dl_idx[i] <= '0;
               end
            end else begin
               dl_v[0]   <= issue_v;
               dl_idx[0] <= issue_cnt;
               for (int unsigned i = 1; i < SBOX_LAT; i++) begin
                  dl_v[i]   <= dl_v[i-1];
                  dl_idx[i] <= dl_idx[i-1];
               end
            end
         end
         assign ret_v   = dl_v[SBOX_LAT-1];
         assign ret_idx = dl_idx[SBOX_LAT-1];
      end
   endgenerate

   // Completion is decided on the retire happening this cycle so DONE follows the last write-back directly
   assign last_retire = ret_v && (retire_cnt == 5'd15);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start) state_d = RUN;
         RUN:     if (issue_cnt == 4'd15) state_d = last_retire ? DONE : DRAIN;
         DRAIN:   if (last_retire) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         issue_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            issue_cnt  <= '0;
            retire_cnt <= '0;
         end else begin
            if (issue_v) issue_cnt <= issue_cnt + 4'd1;
            if (ret_v) retire_cnt <= retire_cnt + 5'd1;
         end
      end
   end

   // One register per share; each sees only its own input and its own S-box output
   always_ff @(posedge i_clk) begin
      if (i_rst) sh0_q <= '0;
      else if (load) sh0_q <= i_state0;
      else if (ret_v) sh0_q[ret_base +: 4] <= i_sb_out0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) sh1_q <= '0;
      else if (load) sh1_q <= i_state1;
      else if (ret_v) sh1_q[ret_base +: 4] <= i_sb_out1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) sh2_q <= '0;
      else if (load) sh2_q <= i_state2;
      else if (ret_v) sh2_q[ret_base +: 4] <= i_sb_out2;
   end

`ifdef PRINCE_SEQ_IDLE_ZERO_EN
   assign o_sb_in0 = issue_v ? nib0 : '0;
   assign o_sb_in1 = issue_v ? nib1 : '0;
   assign o_sb_in2 = issue_v ? nib2 : '0;
`else
   logic [0:3] hold0, hold1, hold2;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hold0 <= '0;
         hold1 <= '0;
         hold2 <= '0;
      end else if (issue_v) begin
         hold0 <= nib0;
         hold1 <= nib1;
         hold2 <= nib2;
      end
   end
   assign o_sb_in0 = issue_v ? nib0 : hold0;
   assign o_sb_in1 = issue_v ? nib1 : hold1;
   assign o_sb_in2 = issue_v ? nib2 : hold2;
`endif

   assign o_sb_valid = issue_v;
   assign o_busy     = (state_q == RUN) || (state_q == DRAIN);
   assign o_done     = (state_q == DONE);
   assign o_state0   = sh0_q;
   assign o_state1   = sh1_q;
   assign o_state2   = sh2_q;

endmodule

// File: tb/tb_prince_slayer_seq.sv
// Bench for prince_slayer_seq: three instances (SBOX_LAT 0, 2, 7) driven by a masked S-box model.
module tb_prince_slayer_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start2, starto;
   logic [0:63] s0, s1, s2;

   logic [0:3]  i0_0, i0_1, i0_2, o0_0, o0_1, o0_2;
   logic [0:3]  i2_0, i2_1, i2_2, o2_0, o2_1, o2_2;
   logic [0:3]  i7_0, i7_1, i7_2, o7_0, o7_1, o7_2;
   logic        v0, b0, d0, v2, b2, d2, v7, b7, d7;
   logic [0:63] r0_0, r0_1, r0_2, r2_0, r2_1, r2_2, r7_0, r7_1, r7_2;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hB;  4'h1: return 4'hF;  4'h2: return 4'h3;  4'h3: return 4'h2;
         4'h4: return 4'hA;  4'h5: return 4'hC;  4'h6: return 4'h9;  4'h7: return 4'h1;
         4'h8: return 4'h6;  4'h9: return 4'h7;  4'hA: return 4'h8;  4'hB: return 4'h0;
         4'hC: return 4'hE;  4'hD: return 4'h5;  4'hE: return 4'hD;  default: return 4'h4;
      endcase
   endfunction

   function automatic logic [0:63] slayer(input logic [0:63] x);
      logic [0:63] r;
      for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox(x[4*n +: 4]);
      return r;
   endfunction

   function automatic logic [3:0] nib(input logic [0:63] x, input int j);
      return x[4*j +: 4];
   endfunction

   // Masked S-box model: shares 1/2 pass through, share 0 absorbs the nonlinear result
   function automatic logic [11:0] sbf(input logic [11:0] x);
      logic [3:0] a, b, c;
      a = x[11:8]; b = x[7:4]; c = x[3:0];
      return {sbox(a ^ b ^ c) ^ b ^ c, b, c};
   endfunction

   logic [11:0] p2 [2];
   logic [11:0] p7 [7];
   always @(posedge clk) begin
      p2[0] <= {i2_0, i2_1, i2_2};
      p2[1] <= p2[0];
      p7[0] <= {i7_0, i7_1, i7_2};
      for (int k = 1; k < 7; k++) p7[k] <= p7[k-1];
   end
   always_comb {o0_0, o0_1, o0_2} = sbf({i0_0, i0_1, i0_2});
   always_comb {o2_0, o2_1, o2_2} = sbf(p2[1]);
   always_comb {o7_0, o7_1, o7_2} = sbf(p7[6]);

   prince_slayer_seq #(.SBOX_LAT(0)) u0 (
      .i_clk(clk), .i_rst(rst), .i_start(starto),
      .i_state0(s0), .i_state1(s1), .i_state2(s2),
      .o_sb_in0(i0_0), .o_sb_in1(i0_1), .o_sb_in2(i0_2), .o_sb_valid(v0),
      .i_sb_out0(o0_0), .i_sb_out1(o0_1), .i_sb_out2(o0_2),
      .o_state0(r0_0), .o_state1(r0_1), .o_state2(r0_2), .o_busy(b0), .o_done(d0));

   prince_slayer_seq #(.SBOX_LAT(2)) u2 (
      .i_clk(clk), .i_rst(rst), .i_start(start2),
      .i_state0(s0), .i_state1(s1), .i_state2(s2),
      .o_sb_in0(i2_0), .o_sb_in1(i2_1), .o_sb_in2(i2_2), .o_sb_valid(v2),
      .i_sb_out0(o2_0), .i_sb_out1(o2_1), .i_sb_out2(o2_2),
      .o_state0(r2_0), .o_state1(r2_1), .o_state2(r2_2), .o_busy(b2), .o_done(d2));

   prince_slayer_seq #(.SBOX_LAT(7)) u7 (
      .i_clk(clk), .i_rst(rst), .i_start(starto),
      .i_state0(s0), .i_state1(s1), .i_state2(s2),
      .o_sb_in0(i7_0), .o_sb_in1(i7_1), .o_sb_in2(i7_2), .o_sb_valid(v7),
      .i_sb_out0(o7_0), .i_sb_out1(o7_1), .i_sb_out2(o7_2),
      .o_state0(r7_0), .o_state1(r7_1), .o_state2(r7_2), .o_busy(b7), .o_done(d7));

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   typedef struct {int cyc; logic [3:0] n0, n1, n2;} iss_t;
   typedef struct {int cyc; logic [63:0] res;} done_t;
   typedef struct {logic [0:63] s0, s1, s2, exp;} vec_t;

   iss_t  issq [$];
   done_t doneq [$];
   vec_t  vecs [5];

   task automatic run_vec(input vec_t v);
      iss_t  it;
      done_t dt;
      s0 = v.s0; s1 = v.s1; s2 = v.s2;
      start2 = 1'b1; starto = 1'b1;
      for (int j = 0; j < 16; j++) issq.push_back('{j + 1, nib(v.s0, j), nib(v.s1, j), nib(v.s2, j)});
      doneq.push_back('{19, v.exp});
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         if (v2) begin
            if (issq.size() == 0) chk("issue_extra", 64'(c), 64'(0));
            else begin
               it = issq.pop_front();
               chk("issue_cyc", 64'(c), 64'(it.cyc));
               chk("sb_in0", 64'(i2_0), 64'(it.n0));
               chk("sb_in1", 64'(i2_1), 64'(it.n1));
               chk("sb_in2", 64'(i2_2), 64'(it.n2));
            end
         end else begin
`ifdef PRINCE_SEQ_IDLE_ZERO_EN
            chk("idle_zero", 64'({i2_0, i2_1, i2_2}), 64'(0));
`else
            if (c > 16) chk("hold_nib15", 64'({i2_0, i2_1, i2_2}),
                            64'({nib(v.s0, 15), nib(v.s1, 15), nib(v.s2, 15)}));
`endif
         end
         if (d2) begin
            if (doneq.size() == 0) chk("done_extra", 64'(c), 64'(0));
            else begin
               dt = doneq.pop_front();
               chk("done_cyc2", 64'(c), 64'(dt.cyc));
               chk("result2", r2_0 ^ r2_1 ^ r2_2, dt.res);
            end
         end
         chk("busy2", 64'(b2), 64'(c <= 18));
         chk("valid2", 64'(v2), 64'(c <= 16));
         chk("valid0", 64'(v0), 64'(c <= 16));
         chk("done0", 64'(d0), 64'(c == 17));
         chk("busy0", 64'(b0), 64'(c <= 16));
         chk("valid7", 64'(v7), 64'(c <= 16));
         chk("done7", 64'(d7), 64'(c == 24));
         chk("busy7", 64'(b7), 64'(c <= 23));
         if (d0) chk("result0", r0_0 ^ r0_1 ^ r0_2, v.exp);
         if (d7) chk("result7", r7_0 ^ r7_1 ^ r7_2, v.exp);
         if (c == 1) begin start2 = 1'b0; starto = 1'b0; end
      end
      chk("result2_kept", r2_0 ^ r2_1 ^ r2_2, v.exp);
      chk("issq_left", 64'(issq.size()), 64'(0));
      chk("doneq_left", 64'(doneq.size()), 64'(0));
      issq.delete();
      doneq.delete();
   endtask

   initial begin
      logic [0:63] a, x, m1, m2, m3, m4;
      a  = 64'h0123456789ABCDEF;
      x  = 64'h3C5A96E10F1E2D4B;
      m1 = {$urandom, $urandom} | 64'h1;
      m2 = {$urandom, $urandom} | 64'h100;
      m3 = {$urandom, $urandom} | 64'h10000;
      m4 = {$urandom, $urandom} | 64'h1000000;
      vecs[0] = '{a, 64'h0, 64'h0, slayer(a)};
      vecs[1] = '{a ^ m1 ^ m2, m1, m2, slayer(a)};
      vecs[2] = '{x ^ m3 ^ m4, m3, m4, slayer(x)};
      vecs[3] = '{64'h0, 64'h0, 64'h0, slayer(64'h0)};
      vecs[4] = '{~m1 ^ m4, m4, ~m2 ^ m2, slayer(m1 ^ m2 ^ m2 ^ 64'h0)};
      vecs[4].exp = slayer(vecs[4].s0 ^ vecs[4].s1 ^ vecs[4].s2);

      rst = 1'b1; start2 = 1'b0; starto = 1'b0;
      s0 = '0; s1 = '0; s2 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("rst_state", r2_0 | r2_1 | r2_2, 64'h0);
         chk("rst_sbin", 64'({i2_0, i2_1, i2_2}), 64'h0);
         chk("rst_ctl", 64'({v2, b2, d2, v0, b0, d0, v7, b7, d7}), 64'h0);
      end

      foreach (vecs[i]) run_vec(vecs[i]);

      // Start pulses in cycles 5 and 19 are ignored; the cycle-20 pulse is accepted
      s0 = a; s1 = '0; s2 = '0; start2 = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c <= 19) chk("pulse_valid", 64'(v2), 64'(c <= 16));
         if (c == 19) begin
            chk("pulse_done19", 64'(d2), 64'(1));
            chk("pulse_res19", r2_0 ^ r2_1 ^ r2_2, slayer(a));
         end
         if (c == 20) begin
            chk("pulse_idle20", 64'({b2, d2}), 64'(0));
            chk("pulse_noload", r2_0 ^ r2_1 ^ r2_2, slayer(a));
         end
         if (c == 21) begin
            chk("pulse_busy21", 64'({b2, v2}), 64'(3));
            chk("pulse_nib0", 64'(i2_0), 64'(nib(x, 0)));
         end
         if (c > 20 && c < 39) chk("pulse_nodone", 64'(d2), 64'(0));
         if (c == 39) begin
            chk("pulse_done39", 64'(d2), 64'(1));
            chk("pulse_res39", r2_0 ^ r2_1 ^ r2_2, slayer(x));
         end
         if (c >= 5) s0 = x;
         start2 = (c == 5 || c == 19 || c == 20);
      end

      // Reset during cycle 9 of a run
      s0 = a; s1 = m1; s2 = m2; start2 = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c <= 9) chk("mid_busy", 64'(b2), 64'(1));
         if (c == 10 || c == 11) begin
            chk("mid_rst_ctl", 64'({b2, v2}), 64'(0));
            chk("mid_rst_state", r2_0 | r2_1 | r2_2, 64'h0);
            chk("mid_rst_sbin", 64'({i2_0, i2_1, i2_2}), 64'h0);
         end
         if (c >= 10) chk("mid_no_done", 64'(d2), 64'(0));
         start2 = 1'b0;
         rst = (c == 9);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
